tx_buffer_loader: RTL and testbench

Writer side of the 4-byte transmit buffer. Loads bytes from the board switches into TXBUF on a debounced LOAD button press, then, on a SEND button press, streams the stored bytes oldest-first to the UART transmitter through a start/busy handshake. TXBUF is exported unchanged to the display logic; the block sits between the board I/O and the UART TX core.

---
 rtl/tx_buffer_loader.sv | 148 ++++++++++++++
 tb/tb_tx_buffer_loader.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_buffer_loader.sv
// Writer side of the 4-entry transmit buffer. It loads switch bytes on LOAD presses and
// streams the stored bytes oldest-first to the UART TX through a start/busy handshake.
module tx_buffer_loader #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [7:0]            i_sw,
    input  logic                  i_load_btn,
    input  logic                  i_send_btn,
    input  logic                  i_tx_busy,
    output logic [DEPTH-1:0][7:0] o_txbuf,
    output logic [1:0]            o_wr_ptr,
    output logic [2:0]            o_count,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_start,
    output logic                  o_sending
);

    typedef enum logic [1:0] {
        B_IDLE,
        B_PULSE,
        B_HELD
    } btn_state_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } send_state_e;

    btn_state_e            r_ld_state;
    btn_state_e            r_sd_state;
    send_state_e           r_state;
    logic [DEPTH-1:0][7:0] r_txbuf;
    logic [1:0]            r_wr_ptr;
    logic [1:0]            r_rd_ptr;
    logic [2:0]            r_count;
    logic [2:0]            r_remaining;
    logic [7:0]            r_tx_data;
    logic                  r_tx_start;
    logic                  r_sending;

    logic w_load_stb;
    logic w_send_stb;

    // One strobe per press, however long the button stays down.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ld_state <= B_IDLE;
        end else begin
            case (r_ld_state)
                B_IDLE:  if (i_load_btn) r_ld_state <= B_PULSE;
                B_PULSE: r_ld_state <= B_HELD;
                B_HELD:  if (!i_load_btn) r_ld_state <= B_IDLE;
                default: r_ld_state <= B_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sd_state <= B_IDLE;
        end else begin
            case (r_sd_state)
                B_IDLE:  if (i_send_btn) r_sd_state <= B_PULSE;
                B_PULSE: r_sd_state <= B_HELD;
                B_HELD:  if (!i_send_btn) r_sd_state <= B_IDLE;
                default: r_sd_state <= B_IDLE;
            endcase
        end
    end

    assign w_load_stb = (r_ld_state == B_PULSE);
    assign w_send_stb = (r_sd_state == B_PULSE);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_txbuf     <= '0;
            r_wr_ptr    <= 2'd0;
            r_rd_ptr    <= 2'd0;
            r_count     <= 3'd0;
            r_remaining <= 3'd0;
            r_tx_data   <= 8'h00;
            r_tx_start  <= 1'b0;
            r_sending   <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A send press always swallows a coincident load press.
                    if (w_send_stb) begin
                        if (r_count != 3'd0) begin
                            // count==4 wraps to 0 here, so the oldest entry is wr_ptr itself.
                            r_rd_ptr    <= r_wr_ptr - r_count[1:0];
                            r_remaining <= r_count;
                            r_sending   <= 1'b1;
                            r_state     <= S_START;
                        end
                    end else if (w_load_stb) begin
                        r_txbuf[r_wr_ptr] <= i_sw;
                        r_wr_ptr          <= r_wr_ptr + 2'd1;
                        if (r_count != 3'd4) begin
                            r_count <= r_count + 3'd1;
                        end
                    end
                end
                S_START: begin
                    r_tx_start <= 1'b1;
                    r_tx_data  <= r_txbuf[r_rd_ptr];
                    r_state    <= S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (i_tx_busy) begin
                        r_state <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        r_rd_ptr    <= r_rd_ptr + 2'd1;
                        r_remaining <= r_remaining - 3'd1;
                        if (r_remaining == 3'd1) begin
                            r_count   <= 3'd0;
                            r_sending <= 1'b0;
                            r_state   <= S_IDLE;
                        end else begin
                            r_state <= S_START;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_sending <= 1'b0;
                end
            endcase
        end
    end

    assign o_txbuf    = r_txbuf;
    assign o_wr_ptr   = r_wr_ptr;
    assign o_count    = r_count;
    assign o_tx_data  = r_tx_data;
    assign o_tx_start = r_tx_start;
    assign o_sending  = r_sending;

endmodule

// File: tb/tb_tx_buffer_loader.sv
// Bench for tx_buffer_loader: a transaction-level buffer model plus a UART busy responder,
// directed scenarios with literal expectations, then a randomized button phase.
module tb_tx_buffer_loader;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      sw;
    logic            load_btn;
    logic            send_btn;
    logic            tx_busy;
    logic [3:0][7:0] txbuf;
    logic [1:0]      wr_ptr;
    logic [2:0]      count;
    logic [7:0]      tx_data;
    logic            tx_start;
    logic            sending;

    always #5 clk = ~clk;

    tx_buffer_loader #(.DEPTH(4)) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_sw       (sw),
        .i_load_btn (load_btn),
        .i_send_btn (send_btn),
        .i_tx_busy  (tx_busy),
        .o_txbuf    (txbuf),
        .o_wr_ptr   (wr_ptr),
        .o_count    (count),
        .o_tx_data  (tx_data),
        .o_tx_start (tx_start),
        .o_sending  (sending)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural model: a press takes effect one edge after it is first seen; a send
    // snapshots the valid bytes oldest-first into a queue; each busy high-then-low
    // period retires one byte.
    logic [7:0]      m_buf [4];
    int              m_wr, m_cnt, m_left;
    bit              m_send, m_seen_busy;
    bit              ld_prev, sd_prev, ld_pend, sd_pend;
    bit              started = 0;
    logic [7:0]      mq [$];

    always @(posedge clk) begin
        started = 1;
        if (reset) begin
            for (int i = 0; i < 4; i++) m_buf[i] = 8'h00;
            m_wr = 0; m_cnt = 0; m_left = 0;
            m_send = 0; m_seen_busy = 0;
            ld_prev = 0; sd_prev = 0; ld_pend = 0; sd_pend = 0;
            mq.delete();
        end else begin
            if (m_send) begin
                if (m_seen_busy && !tx_busy) begin
                    m_seen_busy = 0;
                    m_left--;
                    if (m_left == 0) begin
                        m_send = 0;
                        m_cnt  = 0;
                    end
                end else if (tx_busy) begin
                    m_seen_busy = 1;
                end
            end else if (sd_pend) begin
                if (m_cnt > 0) begin
                    for (int i = 0; i < m_cnt; i++) mq.push_back(m_buf[(m_wr - m_cnt + i + 4) % 4]);
                    m_send = 1;
                    m_left = m_cnt;
                    m_seen_busy = 0;
                end
            end else if (ld_pend) begin
                m_buf[m_wr] = sw;
                m_wr = (m_wr + 1) % 4;
                if (m_cnt < 4) m_cnt++;
            end
            ld_pend = load_btn && !ld_prev;
            sd_pend = send_btn && !sd_prev;
            ld_prev = load_btn;
            sd_prev = send_btn;
        end
    end

    // Per-cycle comparison, sampled mid-cycle.
    logic [7:0] log_q [$];
    bit         prev_start = 0;
    bit         saw_sending = 0;

    always @(negedge clk) begin
        if (started) begin
            check("txbuf", txbuf, {m_buf[3], m_buf[2], m_buf[1], m_buf[0]});
            check("wr_ptr", {30'd0, wr_ptr}, m_wr[31:0] & 32'h3);
            check("count", {29'd0, count}, m_cnt);
            check("sending", {31'd0, sending}, {31'd0, m_send});
            if (tx_start) begin
                check("start_while_busy", {31'd0, tx_busy}, 32'd0);
                check("start_twice", {31'd0, prev_start}, 32'd0);
                if (mq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_start: got tx_data %0h expected no tx_start", tx_data);
                end else begin
                    check("tx_data", {24'd0, tx_data}, {24'd0, mq.pop_front()});
                end
                log_q.push_back(tx_data);
            end
            prev_start = tx_start;
            if (sending) saw_sending = 1;
        end
    end

    // UART transmitter stand-in: busy rises 1..3 cycles after a start, holds for a while.
    bit tx_rand = 0;
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                int d;
                int n;
                d = tx_rand ? int'($urandom_range(1, 3)) : 1;
                n = tx_rand ? int'($urandom_range(1, 8)) : 10;
                repeat (d) @(negedge clk);
                tx_busy = 1'b1;
                repeat (n) @(negedge clk);
                tx_busy = 1'b0;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(1);
    endtask

    task automatic press_load(input logic [7:0] v);
        sw = v;
        load_btn = 1'b1;
        tick(1);
        load_btn = 1'b0;
        tick(3);
    endtask

    task automatic press_send();
        send_btn = 1'b1;
        tick(1);
        send_btn = 1'b0;
        tick(2);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sending || tx_busy) && n < 3000) begin
            tick(1);
            n++;
        end
        checks++;
        if (sending || tx_busy) begin
            errors++;
            $display("FAIL %s_timeout: got sending=%0b after %0d cycles expected 0", name, sending, n);
        end
        check({name, "_queue_drained"}, mq.size(), 0);
    endtask

    task automatic check_buf(input string name, input logic [31:0] exp, input int w, input int c);
        check({name, "_txbuf"}, txbuf, exp);
        check({name, "_wr_ptr"}, {30'd0, wr_ptr}, w);
        check({name, "_count"}, {29'd0, count}, c);
    endtask

    initial begin
        logic [7:0] exp3 [4];
        int         ld_left, sd_left;
        exp3 = '{8'h22, 8'h33, 8'h44, 8'h55};
        reset = 1'b1; sw = 8'h00; load_btn = 1'b0; send_btn = 1'b0;
        tick(3);
        reset = 1'b0;
        check("reset_txbuf", txbuf, 32'h0);
        check("reset_wr_ptr", {30'd0, wr_ptr}, 0);
        check("reset_count", {29'd0, count}, 0);
        check("reset_tx_data", {24'd0, tx_data}, 0);
        check("reset_tx_start", {31'd0, tx_start}, 0);
        check("reset_sending", {31'd0, sending}, 0);

        // Two loads, then one long press that must write only once.
        press_load(8'hA5);
        press_load(8'h3C);
        check_buf("t1", 32'h0000_3CA5, 2, 2);
        sw = 8'h77; load_btn = 1'b1;
        tick(50);
        load_btn = 1'b0;
        tick(3);
        check_buf("t1_hold", 32'h0077_3CA5, 3, 3);

        // Five loads overwrite the oldest entry.
        do_reset();
        press_load(8'h11); press_load(8'h22); press_load(8'h33);
        press_load(8'h44); press_load(8'h55);
        check_buf("t2", 32'h4433_2255, 1, 4);

        // Send all four, with a load press in the middle that must be ignored.
        log_q.delete();
        press_send();
        tick(5);
        press_load(8'hEE);
        wait_idle("t3");
        check("t3_nbytes", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) check("t3_seq", {24'd0, log_q[i]}, {24'd0, exp3[i]});
        check_buf("t3_after", 32'h4433_2255, 1, 0);
        check("t3_sending", {31'd0, sending}, 0);

        // Send with an empty buffer does nothing.
        log_q.delete();
        saw_sending = 0;
        press_send();
        tick(10);
        check("t4_nbytes", log_q.size(), 0);
        check("t4_sending", {31'd0, saw_sending}, 0);

        // Coincident load and send: only the stored byte goes out.
        do_reset();
        press_load(8'h5A);
        log_q.delete();
        sw = 8'hC3; load_btn = 1'b1; send_btn = 1'b1;
        tick(1);
        load_btn = 1'b0; send_btn = 1'b0;
        tick(2);
        wait_idle("t5");
        check("t5_nbytes", log_q.size(), 1);
        if (log_q.size() > 0) check("t5_byte", {24'd0, log_q[0]}, 32'h5A);
        check_buf("t5_after", 32'h0000_005A, 1, 0);

        // Reset in the middle of the second byte of three.
        do_reset();
        press_load(8'h01); press_load(8'h02); press_load(8'h03);
        log_q.delete();
        press_send();
        begin
            int n = 0;
            while (!(log_q.size() == 2 && tx_busy) && n < 500) begin
                tick(1);
                n++;
            end
            check("t6_reached_byte2", {31'd0, (log_q.size() == 2 && tx_busy)}, 1);
        end
        reset = 1'b1;
        tick(1);
        check("t6_txbuf", txbuf, 32'h0);
        check("t6_wr_ptr", {30'd0, wr_ptr}, 0);
        check("t6_count", {29'd0, count}, 0);
        check("t6_tx_data", {24'd0, tx_data}, 0);
        check("t6_tx_start", {31'd0, tx_start}, 0);
        check("t6_sending", {31'd0, sending}, 0);
        reset = 1'b0;
        tick(30);
        check("t6_no_more_starts", log_q.size(), 2);
        wait_idle("t6");

        // Randomized presses and transmitter timing against the model.
        tx_rand = 1;
        do_reset();
        ld_left = 1;
        sd_left = 1;
        for (int c = 0; c < 4000; c++) begin
            if (--ld_left <= 0) begin
                if (load_btn) begin
                    load_btn = 1'b0;
                    ld_left = $urandom_range(2, 8);
                end else if ($urandom_range(0, 2) == 0) begin
                    load_btn = 1'b1;
                    sw = 8'($urandom);
                    ld_left = $urandom_range(1, 5);
                end else begin
                    ld_left = 1;
                end
            end
            if (--sd_left <= 0) begin
                if (send_btn) begin
                    send_btn = 1'b0;
                    sd_left = $urandom_range(2, 8);
                end else if ($urandom_range(0, 11) == 0) begin
                    send_btn = 1'b1;
                    sd_left = $urandom_range(1, 4);
                end else begin
                    sd_left = 1;
                end
            end
            tick(1);
        end
        load_btn = 1'b0;
        send_btn = 1'b0;
        tick(3);
        wait_idle("rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish before 2ms");
        $fatal(1, "timeout");
    end

endmodule
